// File: rtl/instr_fetch_control_if.sv
// Instruction-memory fetch bus: request/address from the fetch unit, word/strobe back from memory.
interface instr_fetch_control_if #(
  parameter int ADDR_W = 10
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );
endinterface

// File: rtl/instr_fetch_control.sv
// Multi-cycle RV32I fetch/decode control: fetches over imem req/valid, decodes R-type ALU ops.
// Optional macro ILLEGAL_TRAP_EN: illegal words halt the core and raise the sticky 'illegal' flag.
module instr_fetch_control #(
  parameter int ADDR_W       = 10,
  parameter int RESET_PC     = 0,
  parameter int IMEM_TIMEOUT = 15
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  instr_fetch_control_if.master  imem,
  output logic [4:0]             read_reg_num1,
  output logic [4:0]             read_reg_num2,
  output logic [4:0]             write_reg,
  output logic [3:0]             alu_control,
  output logic                   regwrite,
  output logic [ADDR_W-1:0]      pc,
  output logic                   halted,
  output logic                   fetch_err,
  output logic                   illegal
);

  localparam int                WAIT_W     = $clog2(IMEM_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] RESET_PC_V = RESET_PC[ADDR_W-1:0];
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(IMEM_TIMEOUT - 1);
  localparam logic [6:0]        OP_RTYPE   = 7'b0110011;
  localparam logic [31:0]       ECALL_WORD = 32'h0000_0073;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    HALT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              fetch_err_q, fetch_err_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       op_legal;
  logic       op_ecall;
  logic [3:0] alu_dec;

  assign opcode = instr_q[6:0];
  assign funct3 = instr_q[14:12];
  assign funct7 = instr_q[31:25];

  // Only the ten base R-type ALU ops are legal; funct7 may be 0 or 0x20 and 0x20 only pairs with ADD/SRA slots.
  always_comb begin
    alu_dec  = 4'b0000;
    op_legal = 1'b0;
    op_ecall = (instr_q == ECALL_WORD);
    if (opcode == OP_RTYPE && (funct7 == 7'b0000000 || funct7 == 7'b0100000)) begin
      op_legal = 1'b1;
      unique case ({funct7[5], funct3})
        4'b0_000: alu_dec = 4'b0010;
        4'b1_000: alu_dec = 4'b0100;
        4'b0_111: alu_dec = 4'b0000;
        4'b0_110: alu_dec = 4'b0001;
        4'b0_100: alu_dec = 4'b0011;
        4'b0_001: alu_dec = 4'b0101;
        4'b0_101: alu_dec = 4'b0110;
        4'b1_101: alu_dec = 4'b0111;
        4'b0_010: alu_dec = 4'b1000;
        4'b0_011: alu_dec = 4'b1001;
        default: begin
          alu_dec  = 4'b0000;
          op_legal = 1'b0;
        end
      endcase
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    wait_d      = wait_q;
    fetch_err_d = fetch_err_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d   = illegal_q;
`endif
    regwrite      = 1'b0;
    imem.imem_req = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          wait_d  = '0;
        end
      end
      FETCH: begin
        imem.imem_req = 1'b1;
        if (imem.imem_valid) begin
          instr_d = imem.imem_rdata;
          state_d = DECODE;
        end else if (wait_q == WAIT_LAST) begin
          fetch_err_d = 1'b1;
          state_d     = HALT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      DECODE: begin
        state_d = EXEC;
      end
      EXEC: begin
        if (op_ecall) begin
          state_d = HALT;
        end else if (!op_legal) begin
`ifdef ILLEGAL_TRAP_EN
          illegal_d = 1'b1;
          state_d   = HALT;
`else
          pc_d    = pc_q + ADDR_W'(4);
          wait_d  = '0;
          state_d = FETCH;
`endif
        end else begin
          regwrite = (instr_q[11:7] != 5'd0);
          pc_d     = pc_q + ADDR_W'(4);
          wait_d   = '0;
          state_d  = FETCH;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC_V;
      instr_q     <= '0;
      wait_q      <= '0;
      fetch_err_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      wait_q      <= wait_d;
      fetch_err_q <= fetch_err_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q   <= illegal_d;
`endif
    end
  end

  assign imem.imem_addr = pc_q;
  assign pc             = pc_q;
  assign read_reg_num1  = instr_q[19:15];
  assign read_reg_num2  = instr_q[24:20];
  assign write_reg      = instr_q[11:7];
  assign alu_control    = alu_dec;
  assign halted         = (state_q == HALT);
  assign fetch_err      = fetch_err_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal        = illegal_q;
`else
  assign illegal        = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_control.sv
// Directed bench for instr_fetch_control: memory responder plus scoreboard of expected decode results.
module tb_instr_fetch_control;

  localparam int ADDR_W = 10;

  logic clock;
  logic reset;
  logic start;

  logic [4:0]        read_reg_num1, read_reg_num2, write_reg;
  logic [3:0]        alu_control;
  logic              regwrite, halted, fetch_err, illegal;
  logic [ADDR_W-1:0] pc;

  instr_fetch_control_if #(.ADDR_W(ADDR_W)) bus ();

  instr_fetch_control #(
    .ADDR_W(ADDR_W),
    .RESET_PC(0),
    .IMEM_TIMEOUT(15)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .imem         (bus.master),
    .read_reg_num1(read_reg_num1),
    .read_reg_num2(read_reg_num2),
    .write_reg    (write_reg),
    .alu_control  (alu_control),
    .regwrite     (regwrite),
    .pc           (pc),
    .halted       (halted),
    .fetch_err    (fetch_err),
    .illegal      (illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [3:0] alu;
    logic       rw;
  } exp_t;

  exp_t              sb[$];
  int                checks   = 0;
  int                failures = 0;
  logic [ADDR_W-1:0] exp_pc   = '0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // One fetch/decode/exec pass: answer the fetch after 'delay' wait cycles, then check DECODE, EXEC and the next pc.
  task automatic run_instr(input logic [31:0] word, input int delay, input exp_t e,
                           input bit chk_fields, input logic [ADDR_W-1:0] next_pc, input bit exp_halt);
    int   n = 0;
    int   req_cycles;
    exp_t got;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check_output("req_seen", {31'd0, bus.imem_req}, 32'd1);
    if (bus.imem_req !== 1'b1) return;
    check_output("fetch_addr", {22'd0, bus.imem_addr}, {22'd0, exp_pc});
    req_cycles = 1;
    repeat (delay) begin
      @(negedge clock);
      if (bus.imem_req === 1'b1 && bus.imem_addr === exp_pc) req_cycles++;
    end
    check_output("req_held", req_cycles, delay + 1);
    bus.imem_valid = 1'b1;
    bus.imem_rdata = word;
    sb.push_back(e);
    @(negedge clock);
    bus.imem_valid = 1'b0;
    bus.imem_rdata = $urandom;
    check_output("req_drop", {31'd0, bus.imem_req}, 32'd0);
    check_output("decode_rw", {31'd0, regwrite}, 32'd0);
    @(negedge clock);
    got = sb.pop_front();
    if (chk_fields) begin
      check_output("rs1", {27'd0, read_reg_num1}, {27'd0, got.rs1});
      check_output("rs2", {27'd0, read_reg_num2}, {27'd0, got.rs2});
      check_output("rd",  {27'd0, write_reg},     {27'd0, got.rd});
      check_output("alu", {28'd0, alu_control},   {28'd0, got.alu});
    end
    check_output("exec_rw", {31'd0, regwrite}, {31'd0, got.rw});
    @(negedge clock);
    check_output("next_pc", {22'd0, pc}, {22'd0, next_pc});
    check_output("halted", {31'd0, halted}, {31'd0, exp_halt});
    check_output("no_rw_after", {31'd0, regwrite}, 32'd0);
    exp_pc = next_pc;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    exp_pc = '0;
  endtask

  initial begin
    int c;
    reset = 1'b0;
    start = 1'b0;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = '0;

    @(negedge clock);
    check_output("rst_pc", {22'd0, pc}, 32'd0);
    check_output("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check_output("rst_outs", {read_reg_num1, read_reg_num2, write_reg, alu_control, regwrite, halted, fetch_err, illegal},
                 32'd0);
    reset = 1'b1;

    // add x3,x1,x2 with zero-wait memory
    pulse_start();
    run_instr(32'h002081B3, 0, '{5'd1, 5'd2, 5'd3, 4'b0010, 1'b1}, 1'b1, 10'd4, 1'b0);
    // and x5,x6,x7 answered after 5 wait cycles
    run_instr(32'h007372B3, 5, '{5'd6, 5'd7, 5'd5, 4'b0000, 1'b1}, 1'b1, 10'd8, 1'b0);

    // addi is not R-type
`ifdef ILLEGAL_TRAP_EN
    run_instr(32'h00000013, 0, '{5'd0, 5'd0, 5'd0, 4'b0000, 1'b0}, 1'b0, 10'd8, 1'b1);
    check_output("illegal_flag", {31'd0, illegal}, 32'd1);
    apply_reset();
    pulse_start();
`else
    run_instr(32'h00000013, 0, '{5'd0, 5'd0, 5'd0, 4'b0000, 1'b0}, 1'b0, 10'd12, 1'b0);
    check_output("illegal_tied", {31'd0, illegal}, 32'd0);
`endif

    // walk the pc up to the top of the address space with add x0,x0,x0
    while (exp_pc != 10'd1020) begin
      run_instr(32'h00000033, 0, '{5'd0, 5'd0, 5'd0, 4'b0010, 1'b0}, 1'b1, exp_pc + 10'd4, 1'b0);
    end
    run_instr(32'h00208033, 0, '{5'd1, 5'd2, 5'd0, 4'b0010, 1'b0}, 1'b1, 10'd0, 1'b0);

    // sub x4,x1,x2 then ecall
    run_instr(32'h40208233, 0, '{5'd1, 5'd2, 5'd4, 4'b0100, 1'b1}, 1'b1, 10'd4, 1'b0);
    run_instr(32'h00000073, 0, '{5'd0, 5'd0, 5'd0, 4'b0000, 1'b0}, 1'b0, 10'd4, 1'b1);
    pulse_start();
    @(negedge clock);
    check_output("halt_sticky", {31'd0, halted}, 32'd1);
    check_output("halt_no_req", {31'd0, bus.imem_req}, 32'd0);
    check_output("halt_pc", {22'd0, pc}, 32'd4);

    // memory never answers
    apply_reset();
    pulse_start();
    c = 0;
    while (bus.imem_req === 1'b1 && c < 40) begin
      c++;
      @(negedge clock);
    end
    check_output("timeout_cycles", c, 15);
    check_output("fetch_err", {31'd0, fetch_err}, 32'd1);
    check_output("timeout_halt", {31'd0, halted}, 32'd1);
    check_output("timeout_req", {31'd0, bus.imem_req}, 32'd0);

    // reset asserted in the middle of a fetch, then a stale valid arrives
    apply_reset();
    pulse_start();
    check_output("midfetch_req", {31'd0, bus.imem_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check_output("async_req", {31'd0, bus.imem_req}, 32'd0);
    check_output("async_outs", {read_reg_num1, read_reg_num2, write_reg, alu_control, regwrite, halted, fetch_err, illegal},
                 32'd0);
    check_output("async_pc", {22'd0, pc}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    bus.imem_valid = 1'b1;
    bus.imem_rdata = 32'h002081B3;
    repeat (2) @(negedge clock);
    bus.imem_valid = 1'b0;
    check_output("late_valid_req", {31'd0, bus.imem_req}, 32'd0);
    check_output("late_valid_instr", {27'd0, write_reg}, 32'd0);
    check_output("late_valid_pc", {22'd0, pc}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
